qrs_window_sched: RTL and testbench

QRS_WINDOW_SCHED -- requirements
Module: qrs_window_sched

---
 rtl/alg_pkg.sv | 22 ++
 rtl/qrs_window_sched_sample_timer.sv | 35 +++
 rtl/qrs_window_sched.sv | 219 +++++++++++++++++++++
 tb/tb_qrs_window_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alg_pkg.sv
// Shared state encoding and default timing constants for the QRS window scheduler.
package alg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REFRACT = 3'd1,
        ST_ARMED   = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_REPORT  = 3'd4
    } state_t;

    // 200 ms refractory, 150 ms search, searchback fallback, all at 360 Hz
    localparam int unsigned REFRACT_SAMPLES_DEF = 72;
    localparam int unsigned SEARCH_SAMPLES_DEF  = 54;
    localparam int unsigned SB_DEFAULT_DEF      = 600;

    // Bits needed to hold a count from 0 up to and including n
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/qrs_window_sched_sample_timer.sv
// Loadable saturating sample counter; o_last_c flags that the next strobe reaches i_limit.
module sample_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_last_c
);

    logic [WIDTH-1:0] count;
    logic [WIDTH:0]   count_inc;

    // One extra bit so the compare stays correct when count sits at all-ones
    assign count_inc = {1'b0, count} + (WIDTH + 1)'(1);
    assign o_last_c  = count_inc >= {1'b0, i_limit};

    // Counter register: clear beats load beats increment; saturates at all-ones
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            count <= '0;
        end else if (i_clr) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_ce && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/qrs_window_sched.sv
// QRS search-window scheduler: arms on permission, opens a fixed window on a
// threshold crossing, reports the window maximum, then enforces a refractory.
// While armed, a searchback pulse fires if no crossing arrives in time.
module qrs_window_sched
    import alg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 11,
    parameter int unsigned CTR_WIDTH       = 24,
    parameter int unsigned REFRACT_SAMPLES = REFRACT_SAMPLES_DEF,
    parameter int unsigned SEARCH_SAMPLES  = SEARCH_SAMPLES_DEF,
    parameter int unsigned SB_DEFAULT      = SB_DEFAULT_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_ce,
    input  logic                         i_search_en,
    input  logic [CTR_WIDTH-1:0]         i_ctr,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    input  logic [DATA_WIDTH-1:0]        i_threshold,
    input  logic [DATA_WIDTH-1:0]        i_rr_period,
    input  logic                         i_rr_valid,
    output logic                         o_extremum_found,
    output logic [DATA_WIDTH-1:0]        o_peak_value,
    output logic [CTR_WIDTH-1:0]         o_peak_location,
    output logic                         o_searchback,
    output logic                         o_window_open
);

    localparam int unsigned WIN_W = cnt_width(SEARCH_SAMPLES);
    localparam int unsigned REF_W = cnt_width(REFRACT_SAMPLES);
    localparam int unsigned SB_W  = DATA_WIDTH + 2;

    state_t state;
    state_t state_nxt;

    logic signed [DATA_WIDTH-1:0] win_max;
    logic [CTR_WIDTH-1:0]         win_loc;
    logic [SB_W-1:0]              sb_limit;
    logic [SB_W-1:0]              sb_limit_calc_c;

    logic crossing_c;
    logic max_upd_c;
    logic enter_armed_c;
    logic win_clr_c, win_load_c, win_ce_c, win_last_c;
    logic ref_clr_c, ref_ce_c, ref_last_c;
    logic sb_clr_c, sb_ce_c, sb_last_c, sb_hit_c;

    logic signed [DATA_WIDTH-1:0] peak_val_c;
    logic [CTR_WIDTH-1:0]         peak_loc_c;

    // Strictly positive sample strictly above the unsigned threshold
    assign crossing_c = !i_sample[DATA_WIDTH-1] && (i_sample != '0) &&
                        ($unsigned(i_sample) > i_threshold);

    // Strictly greater keeps the earliest of equal maxima
    assign max_upd_c  = i_ce && (i_sample > win_max);
    assign peak_val_c = max_upd_c ? i_sample : win_max;
    assign peak_loc_c = max_upd_c ? i_ctr : win_loc;

    // 1.625 x RR, widened so the sum cannot overflow
    assign sb_limit_calc_c = i_rr_valid
                           ? (SB_W'(i_rr_period) + SB_W'(i_rr_period >> 1) + SB_W'(i_rr_period >> 3))
                           : SB_W'(SB_DEFAULT);

    assign enter_armed_c = (state_nxt == ST_ARMED) && (state != ST_ARMED);

    // State register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and timer control; losing permission overrides everything
    always_comb begin
        state_nxt  = state;
        win_clr_c  = 1'b0;
        win_load_c = 1'b0;
        win_ce_c   = 1'b0;
        ref_clr_c  = 1'b0;
        ref_ce_c   = 1'b0;
        sb_clr_c   = 1'b0;
        sb_ce_c    = 1'b0;
        sb_hit_c   = 1'b0;
        if (!i_search_en) begin
            state_nxt = ST_IDLE;
            win_clr_c = 1'b1;
            ref_clr_c = 1'b1;
            sb_clr_c  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ARMED;
                    sb_clr_c  = 1'b1;
                end
                ST_ARMED: begin
                    if (i_ce) begin
                        if (crossing_c) begin
                            state_nxt  = ST_SEARCH;
                            win_load_c = 1'b1;
                        end else if (sb_last_c) begin
                            sb_hit_c = 1'b1;
                            sb_clr_c = 1'b1;
                        end else begin
                            sb_ce_c = 1'b1;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (i_ce) begin
                        win_ce_c = 1'b1;
                        if (win_last_c) begin
                            state_nxt = ST_REPORT;
                        end
                    end
                end
                ST_REPORT: begin
                    state_nxt = ST_REFRACT;
                    ref_clr_c = 1'b1;
                    sb_clr_c  = 1'b1;
                end
                ST_REFRACT: begin
                    if (i_ce) begin
                        if (ref_last_c) begin
                            state_nxt = ST_ARMED;
                            sb_clr_c  = 1'b1;
                        end else begin
                            ref_ce_c = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Running window maximum and its sample number
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            win_max <= '0;
            win_loc <= '0;
        end else if (win_load_c) begin
            win_max <= i_sample;
            win_loc <= i_ctr;
        end else if ((state == ST_SEARCH) && max_upd_c) begin
            win_max <= i_sample;
            win_loc <= i_ctr;
        end
    end

    // Searchback limit captured each time the scheduler re-arms
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sb_limit <= '0;
        end else if (enter_armed_c) begin
            sb_limit <= sb_limit_calc_c;
        end
    end

    // Registered outputs, derived from the upcoming state
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_extremum_found <= 1'b0;
            o_searchback     <= 1'b0;
            o_window_open    <= 1'b0;
            o_peak_value     <= '0;
            o_peak_location  <= '0;
        end else begin
            o_extremum_found <= (state_nxt == ST_REPORT);
            o_searchback     <= sb_hit_c;
            o_window_open    <= (state_nxt == ST_SEARCH);
            if ((state == ST_SEARCH) && (state_nxt == ST_REPORT)) begin
                o_peak_value    <= $unsigned(peak_val_c);
                o_peak_location <= peak_loc_c;
            end
        end
    end

    // Search window length
    sample_timer #(.WIDTH(WIN_W)) u_win_timer (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_clr      (win_clr_c),
        .i_load     (win_load_c),
        .i_load_val (WIN_W'(1)),
        .i_ce       (win_ce_c),
        .i_limit    (WIN_W'(SEARCH_SAMPLES)),
        .o_last_c   (win_last_c)
    );

    // Refractory length
    sample_timer #(.WIDTH(REF_W)) u_ref_timer (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_clr      (ref_clr_c),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_ce       (ref_ce_c),
        .i_limit    (REF_W'(REFRACT_SAMPLES)),
        .o_last_c   (ref_last_c)
    );

    // Searchback interval while armed
    sample_timer #(.WIDTH(SB_W)) u_sb_timer (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_clr      (sb_clr_c),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_ce       (sb_ce_c),
        .i_limit    (sb_limit),
        .o_last_c   (sb_last_c)
    );

endmodule

// File: tb/tb_qrs_window_sched.sv
// Scoreboard bench for qrs_window_sched: expected reports/searchbacks are queued
// as stimulus is driven and checked when the DUT pulses.
module tb_qrs_window_sched;

    localparam int DW       = 11;
    localparam int CW       = 24;
    localparam int SEARCH_N = 54;
    localparam int REFRACT  = 72;

    typedef struct {
        int value;
        int loc;
    } peak_t;

    logic                 clk;
    logic                 nrst;
    logic                 ce;
    logic                 search_en;
    logic [CW-1:0]        ctr_s;
    logic signed [DW-1:0] sample;
    logic [DW-1:0]        thr;
    logic [DW-1:0]        rr;
    logic                 rr_valid;
    logic                 extremum_found;
    logic [DW-1:0]        peak_value;
    logic [CW-1:0]        peak_location;
    logic                 searchback;
    logic                 window_open;

    int    total;
    int    bad;
    int    ctr;
    int    last_ctr;
    int    thr_val;
    peak_t peak_q[$];
    int    sb_q[$];

    qrs_window_sched dut (
        .i_clk            (clk),
        .i_nrst           (nrst),
        .i_ce             (ce),
        .i_search_en      (search_en),
        .i_ctr            (ctr_s),
        .i_sample         (sample),
        .i_threshold      (thr),
        .i_rr_period      (rr),
        .i_rr_valid       (rr_valid),
        .o_extremum_found (extremum_found),
        .o_peak_value     (peak_value),
        .o_peak_location  (peak_location),
        .o_searchback     (searchback),
        .o_window_open    (window_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Scoreboard: pop an expectation whenever the DUT pulses
    always @(negedge clk) begin
        if (extremum_found === 1'b1) begin
            total++;
            if (peak_q.size() == 0) begin
                bad++;
                $display("FAIL report_unexpected: got value=%0d loc=%0d, required no report",
                         peak_value, peak_location);
            end else begin
                peak_t e;
                e = peak_q.pop_front();
                if (peak_value !== DW'(e.value) || peak_location !== CW'(e.loc)) begin
                    bad++;
                    $display("FAIL report: got value=%0d loc=%0d, required value=%0d loc=%0d",
                             peak_value, peak_location, e.value, e.loc);
                end
            end
        end
        if (searchback === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL searchback_unexpected: got pulse after ctr=%0d, required none", last_ctr);
            end else begin
                int e;
                e = sb_q.pop_front();
                if (last_ctr != e) begin
                    bad++;
                    $display("FAIL searchback: got pulse after ctr=%0d, required after ctr=%0d", last_ctr, e);
                end
            end
        end
    end

    // One strobed sample followed by one idle clock
    task automatic send(input int v);
        ce       = 1'b1;
        sample   = DW'(v);
        ctr_s    = CW'(ctr);
        last_ctr = ctr;
        @(posedge clk); #1;
        ce  = 1'b0;
        ctr = ctr + 1;
        @(posedge clk); #1;
    endtask

    // Compute the expected window result from the armed state, then drive it
    task automatic play(input int seq[$]);
        int    started;
        int    cnt;
        int    base;
        peak_t e;
        started = 0;
        cnt     = 0;
        base    = ctr;
        e.value = 0;
        e.loc   = 0;
        foreach (seq[i]) begin
            if (started == 0) begin
                if (seq[i] > 0 && seq[i] > thr_val) begin
                    started = 1;
                    cnt     = 1;
                    e.value = seq[i];
                    e.loc   = base + i;
                end
            end else if (cnt < SEARCH_N) begin
                cnt++;
                if (seq[i] > e.value) begin
                    e.value = seq[i];
                    e.loc   = base + i;
                end
            end
        end
        if (cnt == SEARCH_N) peak_q.push_back(e);
        foreach (seq[i]) send(seq[i]);
    endtask

    task automatic arm();
        search_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic disarm();
        search_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (extremum_found !== 1'b0) begin bad++; $display("FAIL reset_found: got %b required 0", extremum_found); end
        total++;
        if (searchback !== 1'b0) begin bad++; $display("FAIL reset_sb: got %b required 0", searchback); end
        total++;
        if (window_open !== 1'b0) begin bad++; $display("FAIL reset_open: got %b required 0", window_open); end
        total++;
        if (peak_value !== '0) begin bad++; $display("FAIL reset_value: got %0d required 0", peak_value); end
        total++;
        if (peak_location !== '0) begin bad++; $display("FAIL reset_loc: got %0d required 0", peak_location); end
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_peak();
        int seq[$];
        ctr = 100;
        arm();
        seq = {0, 100, -300, 150, 180, 170};
        for (int i = 0; i < 51; i++) seq.push_back(10);
        for (int i = 0; i < 5; i++) seq.push_back(10);
        play(seq);
        total++;
        if (window_open !== 1'b0) begin bad++; $display("FAIL basic_open: got %b required 0", window_open); end
        repeat (6) begin @(posedge clk); #1; end
        total++;
        if (peak_value !== DW'(180) || peak_location !== CW'(104)) begin
            bad++;
            $display("FAIL basic_hold: got value=%0d loc=%0d required 180/104", peak_value, peak_location);
        end
        total++;
        if (peak_q.size() != 0) begin bad++; $display("FAIL basic_drain: got %0d pending required 0", peak_q.size()); end
        disarm();
    endtask

    task automatic test_tie();
        int seq[$];
        ctr = 995;
        arm();
        seq = {150};
        for (int i = 0; i < 4; i++) seq.push_back(50);
        seq.push_back(200);
        for (int i = 0; i < 9; i++) seq.push_back(50);
        seq.push_back(200);
        for (int i = 0; i < 38; i++) seq.push_back(10);
        play(seq);
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (peak_location !== CW'(1000)) begin bad++; $display("FAIL tie_loc: got %0d required 1000", peak_location); end
        total++;
        if (peak_q.size() != 0) begin bad++; $display("FAIL tie_drain: got %0d pending required 0", peak_q.size()); end
        disarm();
    endtask

    task automatic test_refract();
        int    seq[$];
        peak_t e;
        ctr = 2000;
        arm();
        seq = {120};
        for (int i = 0; i < SEARCH_N - 1; i++) seq.push_back(10);
        play(seq);
        for (int i = 0; i < REFRACT; i++) send(500);
        total++;
        if (window_open !== 1'b0) begin bad++; $display("FAIL refract_open: got %b required 0", window_open); end
        e.value = 300;
        e.loc   = ctr;
        peak_q.push_back(e);
        send(300);
        total++;
        if (window_open !== 1'b1) begin bad++; $display("FAIL refract_reopen: got %b required 1", window_open); end
        for (int i = 0; i < SEARCH_N - 1; i++) send(10);
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (peak_q.size() != 0) begin bad++; $display("FAIL refract_drain: got %0d pending required 0", peak_q.size()); end
        disarm();
    endtask

    task automatic test_sb_default();
        ctr      = 5000;
        rr_valid = 1'b0;
        rr       = DW'(288);
        arm();
        sb_q.push_back(ctr + 599);
        for (int i = 0; i < 605; i++) send(5);
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL sb_default_drain: got %0d pending required 0", sb_q.size()); end
        disarm();
    endtask

    task automatic test_sb_rr();
        ctr      = 8000;
        rr_valid = 1'b1;
        rr       = DW'(288);
        arm();
        sb_q.push_back(ctr + 467);
        sb_q.push_back(ctr + 935);
        for (int i = 0; i < 940; i++) send(5);
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL sb_rr_drain: got %0d pending required 0", sb_q.size()); end
        disarm();
    endtask

    task automatic test_sb_vs_cross();
        int seq[$];
        ctr = 12000;
        arm();
        for (int i = 0; i < 467; i++) seq.push_back(5);
        seq.push_back(250);
        for (int i = 0; i < SEARCH_N - 1; i++) seq.push_back(10);
        play(seq);
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (peak_value !== DW'(250)) begin bad++; $display("FAIL sb_cross_value: got %0d required 250", peak_value); end
        total++;
        if (peak_q.size() != 0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_cross_drain: got %0d/%0d pending required 0/0", peak_q.size(), sb_q.size());
        end
        disarm();
        rr_valid = 1'b0;
    endtask

    task automatic test_abort();
        ctr = 14000;
        arm();
        send(150);
        total++;
        if (window_open !== 1'b1) begin bad++; $display("FAIL abort_open: got %b required 1", window_open); end
        for (int i = 0; i < 5; i++) send(10);
        search_en = 1'b0;
        @(posedge clk); #1;
        total++;
        if (window_open !== 1'b0) begin bad++; $display("FAIL abort_closed: got %b required 0", window_open); end
        total++;
        if (extremum_found !== 1'b0) begin bad++; $display("FAIL abort_found: got %b required 0", extremum_found); end
        for (int i = 0; i < 60; i++) send(10);
        arm();
        for (int i = 0; i < 60; i++) send(10);
        total++;
        if (window_open !== 1'b0) begin bad++; $display("FAIL abort_rearm_open: got %b required 0", window_open); end
        disarm();
    endtask

    task automatic test_reset_refract();
        int seq[$];
        ctr = 16000;
        arm();
        seq = {130};
        for (int i = 0; i < SEARCH_N - 1; i++) seq.push_back(10);
        play(seq);
        for (int i = 0; i < 10; i++) send(500);
        #2;
        nrst = 1'b0;
        #1;
        total++;
        if ({extremum_found, searchback, window_open} !== 3'b000 || peak_value !== '0 || peak_location !== '0) begin
            bad++;
            $display("FAIL reset_mid_refract: got f=%b sb=%b open=%b value=%0d loc=%0d required all 0",
                     extremum_found, searchback, window_open, peak_value, peak_location);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        send(400);
        total++;
        if (window_open !== 1'b1) begin bad++; $display("FAIL reset_rearm_open: got %b required 1", window_open); end
        #2;
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 60; i++) send(10);
        total++;
        if (window_open !== 1'b0) begin bad++; $display("FAIL reset_search_open: got %b required 0", window_open); end
        total++;
        if (peak_q.size() != 0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL reset_drain: got %0d/%0d pending required 0/0", peak_q.size(), sb_q.size());
        end
        disarm();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        ctr       = 0;
        last_ctr  = 0;
        thr_val   = 100;
        nrst      = 1'b0;
        ce        = 1'b0;
        search_en = 1'b0;
        ctr_s     = '0;
        sample    = '0;
        thr       = DW'(100);
        rr        = '0;
        rr_valid  = 1'b0;

        test_reset();
        test_basic_peak();
        test_tie();
        test_refract();
        test_sb_default();
        test_sb_rr();
        test_sb_vs_cross();
        test_abort();
        test_reset_refract();

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
